// File: rtl/ka_seq_mult.sv
// ka_seq_mult -- sequential Karatsuba multiplier, y = a * b (unsigned).
//
// Each operand is split into a low half of H = (WIDTH+1)/2 bits and a
// zero-extended high half. A single shared (H+1)x(H+1) multiplier is time
// multiplexed over three cycles to form z0 = aL*bL, z2 = aH*bH and
// zm = (aL+aH)*(bL+bH). A fourth cycle combines them into the product.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair on a/b is valid
//   in_ready   block can accept an operand pair (IDLE only)
//   a, b       unsigned operands, WIDTH bits
//   out_valid  y holds a completed product (DONE only)
//   out_ready  consumer accepts y
//   y          unsigned product, 2*WIDTH bits
//   busy       high in every state except IDLE
module ka_seq_mult #(
  parameter int WIDTH = 93
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               busy
);

  localparam int H  = (WIDTH + 1) / 2;
  localparam int PW = 2 * H + 2;
  localparam int YW = 2 * WIDTH;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P0   = 3'd1;
  localparam logic [2:0] S_P2   = 3'd2;
  localparam logic [2:0] S_PM   = 3'd3;
  localparam logic [2:0] S_COMB = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]       state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [PW-1:0]    z0;
  logic [PW-1:0]    z2;
  logic [PW-1:0]    zm;

  logic [H-1:0]     a_lo;
  logic [H-1:0]     a_hi;
  logic [H-1:0]     b_lo;
  logic [H-1:0]     b_hi;
  logic [H:0]       sum_a;
  logic [H:0]       sum_b;
  logic [H:0]       mul_x;
  logic [H:0]       mul_y;
  logic [PW-1:0]    prod;
  logic [PW-1:0]    z1;
  logic [YW-1:0]    y_next;

  assign a_lo  = a_r[H-1:0];
  assign b_lo  = b_r[H-1:0];
  assign a_hi  = H'(a_r[WIDTH-1:H]);
  assign b_hi  = H'(b_r[WIDTH-1:H]);
  assign sum_a = (H+1)'(a_lo) + (H+1)'(a_hi);
  assign sum_b = (H+1)'(b_lo) + (H+1)'(b_hi);

  // Operand select for the one shared multiplier; the state decides which
  // partial product is being formed this cycle.
  always_comb begin
    mul_x = sum_a;
    mul_y = sum_b;
    case (state)
      S_P0: begin
        mul_x = (H+1)'(a_lo);
        mul_y = (H+1)'(b_lo);
      end
      S_P2: begin
        mul_x = (H+1)'(a_hi);
        mul_y = (H+1)'(b_hi);
      end
      default: begin
        mul_x = sum_a;
        mul_y = sum_b;
      end
    endcase
  end

  assign prod = PW'(mul_x) * PW'(mul_y);

  // zm >= z0 + z2 always, so z1 never wraps. The true product fits in YW
  // bits, so dropping carries above YW during the combine is exact.
  assign z1     = zm - z2 - z0;
  assign y_next = (YW'(z2) << (2 * H)) + (YW'(z1) << H) + YW'(z0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      z0    <= '0;
      z2    <= '0;
      zm    <= '0;
      y     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            state <= S_P0;
          end
        end
        S_P0: begin
          z0    <= prod;
          state <= S_P2;
        end
        S_P2: begin
          z2    <= prod;
          state <= S_PM;
        end
        S_PM: begin
          zm    <= prod;
          state <= S_COMB;
        end
        S_COMB: begin
          y     <= y_next;
          state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ka_seq_mult.sv
// tb_ka_seq_mult -- self-checking bench for ka_seq_mult.
// Five instances (WIDTH 8, 93, 4, 7, 128) share clk/rst; index 0..4 selects
// one through the set_in/get_y helpers. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_ka_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic iv[5];
  logic ordy[5];
  logic ir[5];
  logic ov[5];
  logic bz[5];

  logic [7:0]   a0, b0;  logic [15:0]  y0;
  logic [92:0]  a1, b1;  logic [185:0] y1;
  logic [3:0]   a2, b2;  logic [7:0]   y2;
  logic [6:0]   a3, b3;  logic [13:0]  y3;
  logic [127:0] a4, b4;  logic [255:0] y4;

  ka_seq_mult #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a0), .b(b0),
    .out_valid(ov[0]), .out_ready(ordy[0]), .y(y0), .busy(bz[0]));
  ka_seq_mult #(.WIDTH(93)) u_w93 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a1), .b(b1),
    .out_valid(ov[1]), .out_ready(ordy[1]), .y(y1), .busy(bz[1]));
  ka_seq_mult #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a2), .b(b2),
    .out_valid(ov[2]), .out_ready(ordy[2]), .y(y2), .busy(bz[2]));
  ka_seq_mult #(.WIDTH(7)) u_w7 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(a3), .b(b3),
    .out_valid(ov[3]), .out_ready(ordy[3]), .y(y3), .busy(bz[3]));
  ka_seq_mult #(.WIDTH(128)) u_w128 (
    .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]), .a(a4), .b(b4),
    .out_valid(ov[4]), .out_ready(ordy[4]), .y(y4), .busy(bz[4]));

  function automatic int width_of(input int idx);
    case (idx)
      0:       return 8;
      1:       return 93;
      2:       return 4;
      3:       return 7;
      default: return 128;
    endcase
  endfunction

  function automatic logic [255:0] get_y(input int idx);
    case (idx)
      0:       return 256'(y0);
      1:       return 256'(y1);
      2:       return 256'(y2);
      3:       return 256'(y3);
      default: return y4;
    endcase
  endfunction

  task automatic set_in(input int idx, input logic v, input logic [127:0] x,
                        input logic [127:0] z, input logic r);
    iv[idx]   = v;
    ordy[idx] = r;
    case (idx)
      0:       begin a0 = x[7:0];  b0 = z[7:0];  end
      1:       begin a1 = x[92:0]; b1 = z[92:0]; end
      2:       begin a2 = x[3:0];  b2 = z[3:0];  end
      3:       begin a3 = x[6:0];  b3 = z[6:0];  end
      default: begin a4 = x;       b4 = z;       end
    endcase
  endtask

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Called on a falling edge. Presents a/b, waits for acceptance, then keeps
  // in_valid high with garbage operands while busy (must be ignored).
  // Returns on the falling edge where out_valid is first seen, with
  // out_ready still low. lat counts rising edges, the accepting edge being
  // the first one.
  task automatic run_op(input int idx, input logic [127:0] x,
                        input logic [127:0] z, output logic [255:0] yv,
                        output int lat);
    int guard;
    set_in(idx, 1'b1, x, z, 1'b0);
    guard = 0;
    while (!ir[idx] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!ir[idx]) check("accept_timeout", 256'(ir[idx]), 256'd1);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    set_in(idx, 1'b1, ~x, ~z, 1'b0);
    check("busy_in_ready", 256'({ir[idx], bz[idx]}), 256'b01);
    for (int k = 0; k < 20; k++) begin
      if (ov[idx]) break;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    yv = get_y(idx);
  endtask

  // Called on the falling edge in DONE: consume and expect IDLE next cycle.
  task automatic finish_op(input int idx);
    set_in(idx, 1'b0, '0, '0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(idx, 1'b0, '0, '0, 1'b0);
    check("after_consume", 256'({ir[idx], ov[idx], bz[idx]}), 256'b100);
  endtask

  // Random in_valid/out_ready traffic against a queue of reference products.
  task automatic rand_test(input int idx, input int n);
    logic [255:0] q[$];
    logic [255:0] ys;
    logic [127:0] msk, ra, rb;
    logic irs, ovs, v, r;
    int   accepted, cyc, w;
    w = width_of(idx);
    msk = (128'd1 << w) - 128'd1;
    if (w == 128) msk = '1;
    accepted = 0;
    cyc = 0;
    while ((accepted < n || q.size() != 0) && cyc < 20 * n + 200) begin
      irs = ir[idx];
      ovs = ov[idx];
      ys  = get_y(idx);
      v   = (accepted < n) && ($urandom_range(0, 1) == 1);
      r   = ($urandom_range(0, 3) != 0);
      ra  = {$urandom, $urandom, $urandom, $urandom} & msk;
      rb  = {$urandom, $urandom, $urandom, $urandom} & msk;
      if ($urandom_range(0, 15) == 0) ra = msk;
      if ($urandom_range(0, 15) == 0) rb = '0;
      set_in(idx, v, ra, rb, r);
      if (v && irs) begin
        q.push_back(256'(ra) * 256'(rb));
        accepted++;
      end
      if (ovs && r) begin
        if (q.size() == 0) check("rand_unexpected_out", 256'd1, 256'd0);
        else check("rand_y", ys, q.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    check("rand_drained", 256'(q.size()), 256'd0);
    check("rand_accepted", 256'(accepted), 256'(n));
    set_in(idx, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
  } vec8_t;

  vec8_t        tbl[8];
  logic [255:0] yv;
  int           lat;
  int           seen;
  logic [127:0] ones93;

  initial begin
    tbl[0] = '{a: 8'hFF, b: 8'hFF, y: 16'hFE01};
    tbl[1] = '{a: 8'hA5, b: 8'h3C, y: 16'h26AC};
    tbl[2] = '{a: 8'h03, b: 8'h05, y: 16'h000F};
    tbl[3] = '{a: 8'h00, b: 8'h00, y: 16'h0000};
    tbl[4] = '{a: 8'h01, b: 8'hFF, y: 16'h00FF};
    tbl[5] = '{a: 8'h80, b: 8'h80, y: 16'h4000};
    tbl[6] = '{a: 8'h0F, b: 8'hF0, y: 16'h0E10};
    tbl[7] = '{a: 8'h12, b: 8'h34, y: 16'h03A8};

    rst = 1'b1;
    for (int i = 0; i < 5; i++) set_in(i, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("reset_flags", 256'({ir[i], ov[i], bz[i]}), 256'b100);
      check("reset_y", get_y(i), 256'd0);
    end
    rst = 1'b0;

    // First operation presented right after reset release.
    for (int i = 0; i < 8; i++) begin
      run_op(0, 128'(tbl[i].a), 128'(tbl[i].b), yv, lat);
      check($sformatf("w8_y[%0d]", i), yv, 256'(tbl[i].y));
      check($sformatf("w8_lat[%0d]", i), 256'(lat), 256'd5);
      finish_op(0);
    end

    // WIDTH=93 corners.
    run_op(1, '0, '0, yv, lat);
    check("w93_zero_y", yv, 256'd0);
    check("w93_zero_lat", 256'(lat), 256'd5);
    finish_op(1);
    ones93 = (128'd1 << 93) - 128'd1;
    run_op(1, ones93, ones93, yv, lat);
    check("w93_ones_y", yv,
          (256'd1 << 186) - (256'd1 << 94) + 256'd1);
    finish_op(1);

    // Backpressure: hold DONE for 10 cycles with inputs toggling.
    run_op(0, 128'h0A5, 128'h03C, yv, lat);
    check("bp_y_first", yv, 256'h26AC);
    for (int k = 0; k < 10; k++) begin
      set_in(0, (k % 2) == 0, 128'($urandom), 128'($urandom), 1'b0);
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_y", get_y(0), 256'h26AC);
      check("bp_hold_flags", 256'({ir[0], ov[0], bz[0]}), 256'b011);
    end
    finish_op(0);

    // Reset while in PM.
    set_in(0, 1'b1, 128'h0F, 128'h0F, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_in(0, 1'b0, '0, '0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_pm_flags", 256'({ir[0], ov[0], bz[0]}), 256'b100);
    check("rst_pm_y", get_y(0), 256'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    check("rst_pm_no_out", 256'(seen), 256'd0);
    set_in(0, 1'b0, '0, '0, 1'b0);
    run_op(0, 128'd3, 128'd5, yv, lat);
    check("after_rst_y", yv, 256'd15);
    check("after_rst_lat", 256'(lat), 256'd5);

    // Reset while in DONE discards the pending result.
    rst = 1'b1;
    #1;
    check("rst_done_flags", 256'({ir[0], ov[0], bz[0]}), 256'b100);
    @(negedge clk);
    rst = 1'b0;
    set_in(0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);

    rand_test(2, 400);
    rand_test(3, 400);
    rand_test(0, 300);
    rand_test(1, 300);
    rand_test(4, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
